trans_issuer: RTL and testbench

TRANS_ISSUER -- requirements
Module: trans_issuer

---
 rtl/trans_issuer.sv | 154 +++++++++++++++
 tb/tb_trans_issuer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trans_issuer.sv
// Transaction issuer: buffers packed transfer words in a FIFO and offers them one
// at a time to a validator, with ack/result timeouts and saturating outcome counters.
module trans_issuer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ACK_TIMEOUT    = 8,
  parameter int unsigned RESULT_TIMEOUT = 16384,
  parameter int unsigned POST_GAP       = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [47:0]  in_sender,
  input  logic [47:0]  in_receiver,
  input  logic [21:0]  in_amount,
  input  logic         in_block_start,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] data_o,
  output logic         valid_o,
  input  logic         ack_i,
  input  logic         result_valid_i,
  output logic [15:0]  accepted_cnt,
  output logic [15:0]  rejected_cnt,
  output logic [15:0]  noack_cnt,
  output logic         busy
);

  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CW       = PW + 1;
  localparam int unsigned T_AR     = (ACK_TIMEOUT > RESULT_TIMEOUT) ? ACK_TIMEOUT : RESULT_TIMEOUT;
  localparam int unsigned TMAX     = (T_AR > POST_GAP) ? T_AR : POST_GAP;
  localparam int unsigned TW       = $clog2(TMAX + 1);
  localparam int unsigned GAP_LAST = (POST_GAP == 0) ? 0 : POST_GAP - 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESULT, GAP} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [127:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic [15:0]     accepted_cnt_q, accepted_cnt_d;
  logic [15:0]     rejected_cnt_q, rejected_cnt_d;
  logic [15:0]     noack_cnt_q, noack_cnt_d;

  logic [127:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full, empty, push, pop;
  logic [127:0]    in_word;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  assign in_word = {in_sender, in_receiver, in_amount, in_block_start, 9'd0};
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push    = in_valid && !full;

  // FIFO storage carries no reset; an empty count is what makes it empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= in_word;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q + TW'(1);
    data_d         = data_q;
    valid_d        = valid_q;
    accepted_cnt_d = accepted_cnt_q;
    rejected_cnt_d = rejected_cnt_q;
    noack_cnt_d    = noack_cnt_q;
    pop            = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          data_d  = fifo_mem[rd_ptr_q];
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // ack takes priority over a timeout expiring in the same cycle
        if (ack_i) begin
          valid_d = 1'b0;
          state_d = WAIT_RESULT;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          valid_d     = 1'b0;
          noack_cnt_d = sat_inc(noack_cnt_q);
          state_d     = IDLE;
        end
      end
      WAIT_RESULT: begin
        if (result_valid_i) begin
          accepted_cnt_d = sat_inc(accepted_cnt_q);
          state_d        = (POST_GAP == 0) ? IDLE : GAP;
        end else if (timer_q == TW'(RESULT_TIMEOUT - 1)) begin
          rejected_cnt_d = sat_inc(rejected_cnt_q);
          state_d        = IDLE;
        end
      end
      GAP: begin
        if (timer_q >= TW'(GAP_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      data_q         <= '0;
      valid_q        <= 1'b0;
      accepted_cnt_q <= '0;
      rejected_cnt_q <= '0;
      noack_cnt_q    <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
      accepted_cnt_q <= accepted_cnt_d;
      rejected_cnt_q <= rejected_cnt_d;
      noack_cnt_q    <= noack_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  assign in_ready     = !full;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign accepted_cnt = accepted_cnt_q;
  assign rejected_cnt = rejected_cnt_q;
  assign noack_cnt    = noack_cnt_q;
  assign busy         = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_trans_issuer.sv
// Self-checking bench for trans_issuer: vector table, directed timeout/reset/saturation
// sequences, then random traffic against a transaction-level queue model.
module tb_trans_issuer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [47:0]  in_sender = '0;
  logic [47:0]  in_receiver = '0;
  logic [21:0]  in_amount = '0;
  logic         in_block_start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_o;
  logic         valid_o;
  logic         ack_i = 1'b0;
  logic         result_valid_i = 1'b0;
  logic [15:0]  accepted_cnt, rejected_cnt, noack_cnt;
  logic         busy;

  always #5 clk = ~clk;

  trans_issuer #(
    .FIFO_DEPTH(4), .ACK_TIMEOUT(8), .RESULT_TIMEOUT(16384), .POST_GAP(3)
  ) dut (
    .clk(clk), .rst(rst),
    .in_sender(in_sender), .in_receiver(in_receiver), .in_amount(in_amount),
    .in_block_start(in_block_start), .in_valid(in_valid), .in_ready(in_ready),
    .data_o(data_o), .valid_o(valid_o), .ack_i(ack_i), .result_valid_i(result_valid_i),
    .accepted_cnt(accepted_cnt), .rejected_cnt(rejected_cnt), .noack_cnt(noack_cnt),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_acc = 0, exp_rej = 0, exp_noack = 0;
  logic [127:0] model_q [$];
  bit push_done = 1'b0;

  typedef struct {
    logic [47:0]  s;
    logic [47:0]  r;
    logic [21:0]  a;
    logic         bs;
    int           ack_dly;
    int           res_dly;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [5];

  function automatic logic [127:0] pack(input logic [47:0] s, input logic [47:0] r,
                                        input logic [21:0] a, input logic bs);
    return {s, r, a, bs, 9'd0};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_accepted"}, 128'(accepted_cnt), 128'(exp_acc));
    check({tag, "_rejected"}, 128'(rejected_cnt), 128'(exp_rej));
    check({tag, "_noack"},    128'(noack_cnt),    128'(exp_noack));
  endtask

  // Called at a negedge; returns at the negedge after the word was pushed.
  task automatic push_word(input logic [47:0] s, input logic [47:0] r,
                           input logic [21:0] a, input logic bs);
    int w;
    w = 0;
    in_sender = s; in_receiver = r; in_amount = a; in_block_start = bs; in_valid = 1'b1;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    check("push_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid_o && cyc < 200) begin @(negedge clk); cyc++; end
    check("valid_wait", 128'(valid_o), 128'(1));
  endtask

  int cyc, h, w;
  logic [127:0] w0, w1;
  bit flag;

  // random-phase variables, one set per process
  logic [63:0]  t1, t2;
  logic [127:0] pw;
  int           pushed;
  logic [127:0] exp_w;
  int           rd, rr, rw;
  bit           acked, stop_r;

  initial begin
    vecs[0] = '{48'h1, 48'h2, 22'd50, 1'b1, 2, 5,
                128'h000000000001_000000000002_0000CA00};
    vecs[1] = '{48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 22'h3FFFFF, 1'b1, 0, 0,
                128'hFFFFFFFFFFFF_FFFFFFFFFFFF_FFFFFE00};
    vecs[2] = '{48'hA5A5A5A5A5A5, 48'h5A5A5A5A5A5A, 22'h155555, 1'b0, 7, 1,
                128'hA5A5A5A5A5A5_5A5A5A5A5A5A_55555400};
    vecs[3] = '{48'h123456789ABC, 48'hDEF012345678, 22'h2AAAAA, 1'b1, 3, 3,
                128'h123456789ABC_DEF012345678_AAAAAA00};
    vecs[4] = '{48'h0, 48'h0, 22'd1, 1'b0, 1, 0, 128'h400};

    repeat (3) @(negedge clk);
    check("rst_valid", 128'(valid_o), 128'(0));
    check("rst_data", data_o, 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_busy", 128'(busy), 128'(0));
    check_counters("rst");
    rst = 1'b0;

    // Vector table; the ack_dly=7 entry lands ack on the final ack-timeout cycle.
    foreach (vecs[i]) begin
      push_word(vecs[i].s, vecs[i].r, vecs[i].a, vecs[i].bs);
      wait_valid(cyc);
      check("issue_latency", 128'(cyc), 128'(1));
      check("pack", data_o, vecs[i].exp);
      repeat (vecs[i].ack_dly) @(negedge clk);
      check("hold_valid", 128'(valid_o), 128'(1));
      check("hold_data", data_o, vecs[i].exp);
      ack_i = 1'b1; @(negedge clk); ack_i = 1'b0;
      check("ack_clear", 128'(valid_o), 128'(0));
      check("data_keep", data_o, vecs[i].exp);
      check("noack_unchanged", 128'(noack_cnt), 128'(exp_noack));
      repeat (vecs[i].res_dly) @(negedge clk);
      result_valid_i = 1'b1; @(negedge clk); result_valid_i = 1'b0;
      exp_acc++;
      check("accepted", 128'(accepted_cnt), 128'(exp_acc));
      repeat (2) @(negedge clk);
      check("gap_busy", 128'(busy), 128'(1));
      @(negedge clk);
      check("gap_end", 128'(busy), 128'(0));
    end

    // Five words, no ack: FIFO fills behind the issued word, each times out.
    for (int i = 0; i < 5; i++)
      push_word(48'h100 + 48'(i), 48'h200 + 48'(i), 22'(i + 10), 1'(i));
    check("fifo_full_ready", 128'(in_ready), 128'(0));
    for (int i = 0; i < 5; i++) begin
      wait_valid(cyc);
      if (i > 0) check("to_reissue_lat", 128'(cyc), 128'(1));
      check("to_data", data_o, pack(48'h100 + 48'(i), 48'h200 + 48'(i), 22'(i + 10), 1'(i)));
      h = 0;
      while (valid_o && h < 20) begin @(negedge clk); h++; end
      check("to_hold", 128'(h), 128'((i == 0) ? 5 : 8));
      exp_noack++;
      check("to_noack", 128'(noack_cnt), 128'(exp_noack));
    end
    check("to_in_ready", 128'(in_ready), 128'(1));

    // Result timeout with a second word waiting.
    w0 = pack(48'hAAA, 48'hBBB, 22'd7, 1'b0);
    w1 = pack(48'hCCC, 48'hDDD, 22'd9, 1'b1);
    push_word(48'hAAA, 48'hBBB, 22'd7, 1'b0);
    wait_valid(cyc);
    check("rt_data0", data_o, w0);
    push_word(48'hCCC, 48'hDDD, 22'd9, 1'b1);
    ack_i = 1'b1; @(negedge clk); ack_i = 1'b0;
    w = 1;
    while (rejected_cnt == 16'(exp_rej) && w < 20000) begin @(negedge clk); w++; end
    exp_rej++;
    check("rt_rejected", 128'(rejected_cnt), 128'(exp_rej));
    check("rt_delay", 128'(w), 128'(16385));
    check("rt_valid_low", 128'(valid_o), 128'(0));
    wait_valid(cyc);
    check("rt_next_lat", 128'(cyc), 128'(1));
    check("rt_data1", data_o, w1);
    ack_i = 1'b1; @(negedge clk); ack_i = 1'b0;
    result_valid_i = 1'b1; @(negedge clk); result_valid_i = 1'b0;
    exp_acc++;
    repeat (3) @(negedge clk);
    check_counters("rt");

    // Stray handshakes in IDLE are ignored.
    ack_i = 1'b1; result_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    ack_i = 1'b0; result_valid_i = 1'b0;
    check("stray_idle_valid", 128'(valid_o), 128'(0));
    check("stray_idle_busy", 128'(busy), 128'(0));
    check_counters("stray_idle");

    // Saturation from a preloaded 0xFFFF, with strays during GAP.
    force dut.noack_cnt_q = 16'hFFFF;
    force dut.accepted_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.noack_cnt_q;
    release dut.accepted_cnt_q;
    exp_noack = 65535; exp_acc = 65535;
    push_word(48'h31, 48'h32, 22'd33, 1'b0);
    wait_valid(cyc);
    h = 0;
    while (valid_o && h < 20) begin @(negedge clk); h++; end
    check("sat_noack_hold", 128'(h), 128'(8));
    check("sat_noack", 128'(noack_cnt), 128'(65535));
    push_word(48'h41, 48'h42, 22'd43, 1'b1);
    wait_valid(cyc);
    ack_i = 1'b1; @(negedge clk); ack_i = 1'b0;
    result_valid_i = 1'b1; @(negedge clk);
    ack_i = 1'b1;
    repeat (3) @(negedge clk);
    ack_i = 1'b0; result_valid_i = 1'b0;
    check("sat_acc", 128'(accepted_cnt), 128'(65535));
    check("stray_gap_busy", 128'(busy), 128'(0));
    check("stray_gap_valid", 128'(valid_o), 128'(0));
    check_counters("sat");

    // Reset in WAIT_RESULT with two words queued.
    push_word(48'h51, 48'h52, 22'd53, 1'b0);
    wait_valid(cyc);
    ack_i = 1'b1; @(negedge clk); ack_i = 1'b0;
    push_word(48'h61, 48'h62, 22'd63, 1'b0);
    push_word(48'h71, 48'h72, 22'd73, 1'b1);
    check("mid_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1;
    exp_acc = 0; exp_rej = 0; exp_noack = 0;
    check("mid_rst_valid", 128'(valid_o), 128'(0));
    check("mid_rst_data", data_o, 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check_counters("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    flag = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (valid_o || busy) flag = 1'b1;
    end
    check("post_rst_no_issue", 128'(flag), 128'(0));
    check_counters("post_rst");

    // Random traffic against a queue-of-words model.
    fork
      begin
        pushed = 0;
        while (pushed < 40) begin
          t1 = {$urandom(), $urandom()};
          t2 = {$urandom(), $urandom()};
          in_sender      = t1[47:0];
          in_receiver    = t2[47:0];
          in_amount      = 22'($urandom());
          in_block_start = 1'($urandom());
          in_valid       = ($urandom_range(0, 2) == 0);
          if (in_valid && in_ready) begin
            pw = pack(in_sender, in_receiver, in_amount, in_block_start);
            model_q.push_back(pw);
            pushed++;
          end
          @(negedge clk);
        end
        in_valid = 1'b0;
        push_done = 1'b1;
      end
      begin
        stop_r = 1'b0;
        while (!stop_r) begin
          rw = 0;
          while (!valid_o && !(push_done && model_q.size() == 0) && rw < 300) begin
            @(negedge clk); rw++;
          end
          if (!valid_o) begin
            if (rw >= 300) check("rnd_issue_timeout", 128'(valid_o), 128'(1));
            stop_r = 1'b1;
          end else if (model_q.size() == 0) begin
            check("rnd_unexpected_issue", 128'(valid_o), 128'(0));
            stop_r = 1'b1;
          end else begin
            exp_w = model_q.pop_front();
            rd = $urandom_range(0, 9);
            acked = 1'b0;
            for (int c = 0; c < 8; c++) begin
              check("rnd_valid", 128'(valid_o), 128'(1));
              check("rnd_data", data_o, exp_w);
              if (c == rd) begin
                ack_i = 1'b1; @(negedge clk); ack_i = 1'b0;
                acked = 1'b1;
                break;
              end
              @(negedge clk);
            end
            check("rnd_valid_drop", 128'(valid_o), 128'(0));
            if (acked) begin
              rr = $urandom_range(0, 6);
              repeat (rr) begin ack_i = 1'($urandom()); @(negedge clk); end
              ack_i = 1'b0;
              result_valid_i = 1'b1; @(negedge clk); result_valid_i = 1'b0;
              exp_acc++;
              repeat (3) begin
                ack_i = 1'($urandom()); result_valid_i = 1'($urandom());
                @(negedge clk);
              end
              ack_i = 1'b0; result_valid_i = 1'b0;
            end else begin
              exp_noack++;
            end
          end
        end
      end
    join
    w = 0;
    while (busy && w < 100) begin @(negedge clk); w++; end
    check("rnd_idle", 128'(busy), 128'(0));
    check_counters("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
